// File: rtl/sine_term_sched_pkg.sv
// Shared definitions for the sine-term scheduler: operand/result widths,
// the fixed latency of the attached cubic-term datapath and the requester
// index type used by the arbiter and the tag pipeline.
package sine_term_sched_pkg;

    localparam int ANG_W   = 7;   // angle, unsigned q7.0
    localparam int Y_W     = 30;  // datapath result, q22.8
    localparam int LAT_DEF = 4;   // dp_x update to matching dp_y, in cycles

    typedef logic [0:0] req_idx_t;

    localparam req_idx_t REQ0 = 1'b0;
    localparam req_idx_t REQ1 = 1'b1;

    function automatic req_idx_t other_idx(input req_idx_t i);
        return ~i;
    endfunction

endpackage

// File: rtl/sine_term_sched_rr_arb2.sv
// Two-way round-robin choice.
//   i_eligible  : per-requester eligibility (bit N = requester N)
//   i_rr_ptr    : requester favoured when both are eligible
//   o_grant     : one-hot grant, zero when nobody is eligible
//   o_grant_idx : index of the granted requester (meaningful only with a grant)
module rr_arb2
    import sine_term_sched_pkg::*;
(
    input  logic [1:0] i_eligible,
    input  req_idx_t   i_rr_ptr,
    output logic [1:0] o_grant,
    output req_idx_t   o_grant_idx
);

    always_comb begin
        o_grant     = 2'b00;
        o_grant_idx = i_rr_ptr;
        case (i_eligible)
            2'b01: begin
                o_grant     = 2'b01;
                o_grant_idx = REQ0;
            end
            2'b10: begin
                o_grant     = 2'b10;
                o_grant_idx = REQ1;
            end
            2'b11: begin
                o_grant     = (i_rr_ptr == REQ1) ? 2'b10 : 2'b01;
                o_grant_idx = i_rr_ptr;
            end
            default: begin
                o_grant     = 2'b00;
                o_grant_idx = i_rr_ptr;
            end
        endcase
    end

endmodule

// File: rtl/sine_term_sched.sv
// Shares one fixed-latency cubic-term datapath between two requesters.
// Each requester may have one angle in flight; its result is held until
// consumed. A tag pipeline tracks which requester owns each datapath slot.
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid/theta/ready   : angle request handshake, requester N
//   dp_x / dp_y              : operand to / result from the shared datapath
//   rspN_valid/data/ready    : held result handshake, requester N
//   idle                     : no requester busy
module sine_term_sched
    import sine_term_sched_pkg::*;
#(
    parameter int LAT = LAT_DEF
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [ANG_W-1:0] req0_theta,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [ANG_W-1:0] req1_theta,
    output logic             req1_ready,
    output logic [ANG_W-1:0] dp_x,
    input  logic [Y_W-1:0]   dp_y,
    output logic             rsp0_valid,
    output logic [Y_W-1:0]   rsp0_data,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    output logic [Y_W-1:0]   rsp1_data,
    input  logic             rsp1_ready,
    output logic             idle
);

    logic [1:0]       r_busy;
    req_idx_t         r_rr_ptr;
    logic [ANG_W-1:0] r_dp_x;
    logic [LAT:0]     r_pipe_v;
    req_idx_t         r_pipe_tag [LAT+1];
    logic [1:0]       r_rsp_valid;
    logic [Y_W-1:0]   r_rsp_data [2];

    logic [1:0]       w_eligible;
    logic [1:0]       w_grant_raw;
    logic [1:0]       w_grant;
    req_idx_t         w_grant_idx;
    logic             w_any_grant;
    logic [ANG_W-1:0] w_theta_sel;
    logic [1:0]       w_rsp_hs;
    logic [1:0]       w_emerge;

    assign w_eligible = {req1_valid & ~r_busy[1], req0_valid & ~r_busy[0]};

    rr_arb2 u_arb (
        .i_eligible  (w_eligible),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant_raw),
        .o_grant_idx (w_grant_idx)
    );

    // No handshake may complete while reset is applied.
    assign w_grant     = rst ? 2'b00 : w_grant_raw;
    assign w_any_grant = |w_grant;
    assign w_theta_sel = (w_grant_idx == REQ1) ? req1_theta : req0_theta;

    assign w_rsp_hs    = r_rsp_valid & {rsp1_ready, rsp0_ready};

    // The last tag stage lines up with dp_y for the operand issued LAT+1 edges ago.
    assign w_emerge[0] = r_pipe_v[LAT] & (r_pipe_tag[LAT] == REQ0);
    assign w_emerge[1] = r_pipe_v[LAT] & (r_pipe_tag[LAT] == REQ1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 2'b00;
            r_rr_ptr    <= REQ0;
            r_dp_x      <= '0;
            r_pipe_v    <= '0;
            r_rsp_valid <= 2'b00;
            for (int k = 0; k <= LAT; k++) begin
                r_pipe_tag[k] <= REQ0;
            end
            for (int n = 0; n < 2; n++) begin
                r_rsp_data[n] <= '0;
            end
        end else begin
            if (w_any_grant) begin
                r_dp_x   <= w_theta_sel;
                r_rr_ptr <= other_idx(w_grant_idx);
            end

            r_pipe_v      <= {r_pipe_v[LAT-1:0], w_any_grant};
            r_pipe_tag[0] <= w_grant_idx;
            for (int k = 1; k <= LAT; k++) begin
                r_pipe_tag[k] <= r_pipe_tag[k-1];
            end

            // A requester is never granted while busy, so grant and response
            // handshake for the same index cannot coincide.
            for (int n = 0; n < 2; n++) begin
                if (w_grant[n]) begin
                    r_busy[n] <= 1'b1;
                end else if (w_rsp_hs[n]) begin
                    r_busy[n] <= 1'b0;
                end

                if (w_emerge[n]) begin
                    r_rsp_valid[n] <= 1'b1;
                    r_rsp_data[n]  <= dp_y;
                end else if (w_rsp_hs[n]) begin
                    r_rsp_valid[n] <= 1'b0;
                end
            end
        end
    end

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign dp_x       = r_dp_x;
    assign rsp0_valid = r_rsp_valid[0];
    assign rsp1_valid = r_rsp_valid[1];
    assign rsp0_data  = r_rsp_data[0];
    assign rsp1_data  = r_rsp_data[1];
    assign idle       = ~r_busy[0] & ~r_busy[1];

endmodule

// File: tb/tb_sine_term_sched.sv
module tb_sine_term_sched;
    import sine_term_sched_pkg::*;

    localparam int LAT = LAT_DEF;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [ANG_W-1:0] req0_theta, req1_theta;
    logic             req0_ready, req1_ready;
    logic [ANG_W-1:0] dp_x;
    logic [Y_W-1:0]   dp_y;
    logic             rsp0_valid, rsp1_valid;
    logic [Y_W-1:0]   rsp0_data, rsp1_data;
    logic             rsp0_ready, rsp1_ready;
    logic             idle;

    int total = 0;
    int bad   = 0;

    sine_term_sched #(.LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_theta (req0_theta),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_theta (req1_theta),
        .req1_ready (req1_ready),
        .dp_x       (dp_x),
        .dp_y       (dp_y),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_ready (rsp1_ready),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    function automatic logic [Y_W-1:0] cube43(input logic [ANG_W-1:0] x);
        logic [31:0] t;
        t = 32'(x);
        return Y_W'(32'd43 * t * t * t);
    endfunction

    // Cubic-term datapath model: LAT register stages behind dp_x.
    logic [Y_W-1:0] m_pipe [LAT];
    always @(posedge clk) begin
        m_pipe[0] <= cube43(dp_x);
        for (int k = 1; k < LAT; k++) m_pipe[k] <= m_pipe[k-1];
    end
    assign dp_y = m_pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic get_rv(input req_idx_t n);
        return (n == REQ1) ? rsp1_valid : rsp0_valid;
    endfunction

    function automatic logic [Y_W-1:0] get_rd(input req_idx_t n);
        return (n == REQ1) ? rsp1_data : rsp0_data;
    endfunction

    function automatic logic get_ready(input req_idx_t n);
        return (n == REQ1) ? req1_ready : req0_ready;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic wait_rv(input req_idx_t n, input int max, input string name);
        int c;
        c = 0;
        while (!get_rv(n) && c < max) begin
            step();
            c++;
        end
        chk({name, " arrival"}, 32'(get_rv(n)), 32'd1);
    endtask

    task automatic consume();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        step();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    typedef struct {
        logic             rst_first;
        logic             v0;
        logic [ANG_W-1:0] t0;
        logic             v1;
        logic [ANG_W-1:0] t1;
        logic             first;   // expected first grant when both request
        logic [Y_W-1:0]   d0;
        logic [Y_W-1:0]   d1;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int i, input vec_t v);
        int               e;
        logic             both;
        req_idx_t         f, s;
        logic [ANG_W-1:0] tf, ts;
        logic [Y_W-1:0]   df, ds;
        if (v.rst_first) do_reset();
        both = v.v0 & v.v1;
        f  = both ? req_idx_t'(v.first) : (v.v1 ? REQ1 : REQ0);
        s  = ~f;
        tf = (f == REQ1) ? v.t1 : v.t0;
        ts = (f == REQ1) ? v.t0 : v.t1;
        df = (f == REQ1) ? v.d1 : v.d0;
        ds = (f == REQ1) ? v.d0 : v.d1;
        req0_valid = v.v0; req0_theta = v.t0;
        req1_valid = v.v1; req1_theta = v.t1;
        #1;
        chk($sformatf("v%0d ready0", i), 32'(req0_ready), 32'(f == REQ0));
        chk($sformatf("v%0d ready1", i), 32'(req1_ready), 32'(f == REQ1));
        step(); e = 1;
        if (f == REQ1) req1_valid = 1'b0; else req0_valid = 1'b0;
        chk($sformatf("v%0d dp_x first", i), 32'(dp_x), 32'(tf));
        if (both) begin
            #1;
            chk($sformatf("v%0d second ready", i), 32'(get_ready(s)), 32'd1);
            step(); e = 2;
            req0_valid = 1'b0; req1_valid = 1'b0;
            chk($sformatf("v%0d dp_x second", i), 32'(dp_x), 32'(ts));
        end
        while (e < LAT + 1) begin
            step();
            e++;
        end
        chk($sformatf("v%0d rsp early", i), 32'(get_rv(f)), 32'd0);
        step();
        chk($sformatf("v%0d rsp valid", i), 32'(get_rv(f)), 32'd1);
        chk($sformatf("v%0d rsp data", i), 32'(get_rd(f)), 32'(df));
        if (both) begin
            chk($sformatf("v%0d rsp2 early", i), 32'(get_rv(s)), 32'd0);
            step();
            chk($sformatf("v%0d rsp2 valid", i), 32'(get_rv(s)), 32'd1);
            chk($sformatf("v%0d rsp2 data", i), 32'(get_rd(s)), 32'(ds));
        end
        consume();
        chk($sformatf("v%0d rsp0 cleared", i), 32'(rsp0_valid), 32'd0);
        chk($sformatf("v%0d rsp1 cleared", i), 32'(rsp1_valid), 32'd0);
        chk($sformatf("v%0d idle", i), 32'(idle), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 7'd10,  1'b0, 7'd0,   1'b0, 30'd43000,    30'd0};
        vecs[1] = '{1'b0, 1'b0, 7'd0,   1'b1, 7'd5,   1'b1, 30'd0,        30'd5375};
        vecs[2] = '{1'b1, 1'b1, 7'd127, 1'b1, 7'd2,   1'b0, 30'd88080469, 30'd344};
        vecs[3] = '{1'b0, 1'b1, 7'd0,   1'b1, 7'd1,   1'b0, 30'd0,        30'd43};
        vecs[4] = '{1'b0, 1'b0, 7'd0,   1'b1, 7'd127, 1'b1, 30'd0,        30'd88080469};
        vecs[5] = '{1'b0, 1'b1, 7'd64,  1'b0, 7'd0,   1'b0, 30'd11272192, 30'd0};
        vecs[6] = '{1'b0, 1'b1, 7'd3,   1'b1, 7'd4,   1'b1, 30'd1161,     30'd2752};

        // Reset state, with requests presented while reset is high.
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_theta = 7'd33; req1_theta = 7'd44;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step(); step();
        #1;
        chk("reset ready0", 32'(req0_ready), 32'd0);
        chk("reset ready1", 32'(req1_ready), 32'd0);
        chk("reset idle", 32'(idle), 32'd1);
        chk("reset dp_x", 32'(dp_x), 32'd0);
        chk("reset rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("reset rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("reset rsp0_data", 32'(rsp0_data), 32'd0);
        chk("reset rsp1_data", 32'(rsp1_data), 32'd0);
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Held response with the requester still asking for more.
        req0_valid = 1'b1; req0_theta = 7'd7;
        #1;
        chk("stall grant", 32'(req0_ready), 32'd1);
        step();
        req0_theta = 7'd9;
        wait_rv(REQ0, LAT + 3, "stall rsp0");
        for (int k = 0; k < 20; k++) begin
            chk("stall data", 32'(rsp0_data), 32'd14749);
            chk("stall valid", 32'(rsp0_valid), 32'd1);
            chk("stall ready0", 32'(req0_ready), 32'd0);
            step();
        end
        rsp0_ready = 1'b1;
        #1;
        chk("hs cycle ready0", 32'(req0_ready), 32'd0);
        step();
        rsp0_ready = 1'b0;
        #1;
        chk("after hs rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("regrant ready0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        chk("regrant dp_x", 32'(dp_x), 32'd9);
        wait_rv(REQ0, LAT + 3, "regrant rsp0");
        chk("regrant data", 32'(rsp0_data), 32'd31347);
        consume();

        // Both requesters streaming with random response back-pressure.
        do_reset();
        begin
            int               g0, g1, r0, r1, cyc;
            logic             b0, b1, eg0, eg1;
            req_idx_t         rr_m;
            logic [Y_W-1:0]   e0, e1;
            g0 = 0; g1 = 0; r0 = 0; r1 = 0; cyc = 0;
            b0 = 1'b0; b1 = 1'b0; rr_m = REQ0; e0 = '0; e1 = '0;
            while ((r0 < 100 || r1 < 100) && cyc < 5000) begin
                req0_valid = (g0 < 100);
                req1_valid = (g1 < 100);
                req0_theta = 7'($urandom_range(0, 127));
                req1_theta = 7'($urandom_range(0, 127));
                rsp0_ready = 1'($urandom_range(0, 1));
                rsp1_ready = 1'($urandom_range(0, 1));
                #1;
                eg0 = req0_valid & ~b0;
                eg1 = req1_valid & ~b1;
                if (eg0 && eg1) begin
                    eg0 = (rr_m == REQ0);
                    eg1 = ~eg0;
                end
                chk("stream ready0", 32'(req0_ready), 32'(eg0));
                chk("stream ready1", 32'(req1_ready), 32'(eg1));
                if (rsp0_valid && rsp0_ready) begin
                    chk("stream data0", 32'(rsp0_data), 32'(e0));
                    b0 = 1'b0; r0++;
                end
                if (rsp1_valid && rsp1_ready) begin
                    chk("stream data1", 32'(rsp1_data), 32'(e1));
                    b1 = 1'b0; r1++;
                end
                if (eg0) begin e0 = cube43(req0_theta); b0 = 1'b1; g0++; rr_m = REQ1; end
                if (eg1) begin e1 = cube43(req1_theta); b1 = 1'b1; g1++; rr_m = REQ0; end
                step();
                cyc++;
            end
            req0_valid = 1'b0; req1_valid = 1'b0;
            rsp0_ready = 1'b0; rsp1_ready = 1'b0;
            chk("stream responses", 32'(r0 + r1), 32'd200);
            #1;
            chk("stream idle", 32'(idle), 32'd1);
        end

        // Reset two cycles after a req1 grant discards the in-flight tag.
        step();
        req1_valid = 1'b1; req1_theta = 7'd50;
        #1;
        chk("rst seq grant", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        step();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst ready0 low", 32'(req0_ready), 32'd0);
        chk("rst ready1 low", 32'(req1_ready), 32'd0);
        step();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rst idle", 32'(idle), 32'd1);
        for (int k = 0; k < LAT + 4; k++) begin
            chk("rst no rsp1", 32'(rsp1_valid), 32'd0);
            step();
        end
        req1_valid = 1'b1; req1_theta = 7'd3;
        #1;
        chk("post rst grant", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        wait_rv(REQ1, LAT + 3, "post rst rsp1");
        chk("post rst data", 32'(rsp1_data), 32'd1161);
        consume();
        chk("final idle", 32'(idle), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
